// File: rtl/audio_pkg.sv
// Shared types and constants for the record/playback sequencer.
// Included by audio_seq_ctrl and audio_addr_gen.
package audio_pkg;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 16;
  localparam int SRAM_DEPTH = 262144;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REC   = 2'b01,
    ST_PLAY  = 2'b10,
    ST_PAUSE = 2'b11
  } state_e;
endpackage

// File: rtl/audio_addr_gen.sv
// Write/play pointers, repeat counter, speed step and end-of-data test.
// Pointers are one bit wider than the SRAM address so full depth is countable.
module audio_addr_gen
  import audio_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_start_i,
  input  logic              play_start_i,
  input  logic              wr_adv_i,
  input  logic              rd_adv_i,
  input  logic [2:0]        speed_i,
  input  logic              fast_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W:0]   rec_len_o,
  output logic              wr_last_o,
  output logic              rd_last_o
);
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] pptr_q, pptr_d, pnext;
  logic [2:0]      rep_q, rep_d, rep_nx;
  logic [3:0]      step_k;

  assign step_k = {1'b0, speed_i} + 4'd1;

  always_comb begin
    pnext  = pptr_q;
    rep_nx = rep_q + 3'd1;
    if (fast_i) begin
      pnext  = pptr_q + {{(ADDR_W-3){1'b0}}, step_k};
      rep_nx = 3'd0;
    end else if (rep_q >= speed_i) begin
      pnext  = pptr_q + 1'b1;
      rep_nx = 3'd0;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    pptr_d = pptr_q;
    rep_d  = rep_q;
    if (rec_start_i)
      wptr_d = '0;
    else if (wr_adv_i)
      wptr_d = wptr_q + 1'b1;
    if (play_start_i) begin
      pptr_d = '0;
      rep_d  = 3'd0;
    end else if (rd_adv_i) begin
      pptr_d = pnext;
      rep_d  = rep_nx;
    end else if (fast_i) begin
      rep_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      pptr_q <= '0;
      rep_q  <= 3'd0;
    end else begin
      wptr_q <= wptr_d;
      pptr_q <= pptr_d;
      rep_q  <= rep_d;
    end
  end

  assign wr_addr_o = wptr_q[ADDR_W-1:0];
  assign rd_addr_o = pptr_q[ADDR_W-1:0];
  assign rec_len_o = wptr_q;
  assign wr_last_o = (wptr_q == {1'b0, {ADDR_W{1'b1}}});
  assign rd_last_o = (pnext >= wptr_q);
endmodule

// File: rtl/audio_seq_ctrl.sv
// Transport FSM and SRAM strobe timing for the audio record/play path.
// One SRAM access per frame; reads land in dac_data two cycles after the tick.
module audio_seq_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_play,
  input  logic              btn_rec,
  input  logic              btn_pause,
  input  logic              btn_stop,
  input  logic [2:0]        speed,
  input  logic              fast,
  input  logic              frame_tick,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [DATA_W-1:0] dac_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len
);
  state_e            state_q, nxt_st;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dac_q;
  logic              we_n_q, oe_n_q;
  logic              rd_pend_q, last_q, fin_q;
  logic              act, wr_adv, rd_adv;
  logic              rec_start, play_start;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_last, rd_last;

  // Legal button transitions; an accepted button suppresses this frame's access.
  always_comb begin
    nxt_st = state_q;
    act    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_rec) begin
          nxt_st = ST_REC;
          act    = 1'b1;
        end else if (btn_play && rec_len != '0) begin
          nxt_st = ST_PLAY;
          act    = 1'b1;
        end
      end
      ST_REC: begin
        if (btn_stop) begin
          nxt_st = ST_IDLE;
          act    = 1'b1;
        end
      end
      ST_PLAY: begin
        if (btn_stop) begin
          nxt_st = ST_IDLE;
          act    = 1'b1;
        end else if (btn_pause) begin
          nxt_st = ST_PAUSE;
          act    = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (btn_stop) begin
          nxt_st = ST_IDLE;
          act    = 1'b1;
        end else if (btn_play) begin
          nxt_st = ST_PLAY;
          act    = 1'b1;
        end
      end
    endcase
  end

  assign rec_start  = act && (state_q == ST_IDLE) && (nxt_st == ST_REC);
  assign play_start = act && (state_q == ST_IDLE) && (nxt_st == ST_PLAY);
  assign wr_adv     = frame_tick && !act && (state_q == ST_REC);
  assign rd_adv     = frame_tick && !act && (state_q == ST_PLAY);

  audio_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk         (clk),
    .rst_n       (rst_n),
    .rec_start_i (rec_start),
    .play_start_i(play_start),
    .wr_adv_i    (wr_adv),
    .rd_adv_i    (rd_adv),
    .speed_i     (speed),
    .fast_i      (fast),
    .wr_addr_o   (wr_addr),
    .rd_addr_o   (rd_addr),
    .rec_len_o   (rec_len),
    .wr_last_o   (wr_last),
    .rd_last_o   (rd_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dac_q     <= '0;
      rd_pend_q <= 1'b0;
      last_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      fin_q     <= 1'b0;
      if (act) begin
        state_q <= nxt_st;
        if (nxt_st == ST_IDLE || nxt_st == ST_PAUSE)
          dac_q <= '0;
      end else if (wr_adv) begin
        addr_q  <= wr_addr;
        wdata_q <= adc_data;
        we_n_q  <= 1'b0;
        last_q  <= wr_last;
      end else if (rd_adv) begin
        addr_q    <= rd_addr;
        oe_n_q    <= 1'b0;
        rd_pend_q <= 1'b1;
        last_q    <= rd_last;
      end else if (rd_pend_q) begin
        dac_q <= sram_rdata;
        fin_q <= last_q;
      end else if (!we_n_q && last_q) begin
        state_q <= ST_IDLE;
      end else if (fin_q) begin
        state_q <= ST_IDLE;
        dac_q   <= '0;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;
  assign dac_data   = dac_q;
  assign state      = state_q;
endmodule

// File: tb/tb_audio_seq_ctrl.sv
// Directed bench for audio_seq_ctrl with a behavioural async SRAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_audio_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_play, btn_rec, btn_pause, btn_stop;
  logic [2:0]  speed;
  logic        fast;
  logic        frame_tick;
  logic [15:0] adc_data;
  logic [15:0] sram_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we_n, sram_oe_n;
  logic [15:0] dac_data;
  logic [1:0]  state;
  logic [18:0] rec_len;

  int nvec = 0;
  int nerr = 0;
  int wr_cnt = 0;
  logic [15:0] mem [0:262143];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  audio_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_play  (btn_play),
    .btn_rec   (btn_rec),
    .btn_pause (btn_pause),
    .btn_stop  (btn_stop),
    .speed     (speed),
    .fast      (fast),
    .frame_tick(frame_tick),
    .adc_data  (adc_data),
    .sram_rdata(sram_rdata),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .dac_data  (dac_data),
    .state     (state),
    .rec_len   (rec_len)
  );

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] <= sram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign sram_rdata = sram_oe_n ? 16'hDEAD : mem[sram_addr];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {btn_play, btn_rec, btn_pause, btn_stop} = 4'b0;
    speed = 3'd0; fast = 1'b1; frame_tick = 1'b0; adc_data = 16'h0;
    step(); step();
    nvec++;
    if ({state, sram_we_n, sram_oe_n} !== 4'b0011) begin
      nerr++;
      $display("FAIL reset_st state/we/oe got %b exp 0011", {state, sram_we_n, sram_oe_n});
    end
    nvec++;
    if ({sram_addr, sram_wdata, dac_data, rec_len} !== 67'h0) begin
      nerr++;
      $display("FAIL reset_val addr %h wdata %h dac %h len %h exp all 0",
               sram_addr, sram_wdata, dac_data, rec_len);
    end
    rst_n = 1'b1;
    step();
    btn_play = 1'b1; step(); btn_play = 1'b0; step();
    nvec++;
    if (state !== 2'b00) begin
      nerr++;
      $display("FAIL play_empty state got %b exp 00", state);
    end
  endtask

  task automatic test_record();
    int w0;
    btn_rec = 1'b1; step(); btn_rec = 1'b0;
    nvec++;
    if (state !== 2'b01 || rec_len !== 19'd0) begin
      nerr++;
      $display("FAIL rec_enter state %b len %0d exp 01 0", state, rec_len);
    end
    step(); step();
    w0 = wr_cnt;
    for (int i = 1; i <= 5; i++) begin
      adc_data = 16'(i); frame_tick = 1'b1; step(); frame_tick = 1'b0;
      adc_data = 16'hFFFF;
      nvec++;
      if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 ||
          sram_addr !== 18'(i-1) || sram_wdata !== 16'(i)) begin
        nerr++;
        $display("FAIL rec_wr%0d we %b oe %b addr %h wd %h exp 0 1 %h %h",
                 i, sram_we_n, sram_oe_n, sram_addr, sram_wdata, i-1, i);
      end
      step();
      nvec++;
      if (sram_we_n !== 1'b1 || rec_len !== 19'(i)) begin
        nerr++;
        $display("FAIL rec_pulse%0d we %b len %0d exp 1 %0d", i, sram_we_n, rec_len, i);
      end
      step(); step();
    end
    btn_stop = 1'b1; step(); btn_stop = 1'b0;
    nvec++;
    if (state !== 2'b00 || rec_len !== 19'd5 || wr_cnt - w0 != 5) begin
      nerr++;
      $display("FAIL rec_stop state %b len %0d writes %0d exp 00 5 5", state, rec_len, wr_cnt - w0);
    end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (mem[i] !== 16'(i+1)) begin
        nerr++;
        $display("FAIL rec_mem[%0d] got %h exp %h", i, mem[i], i+1);
      end
    end
    step();
  endtask

  task automatic run_play(input logic f, input logic [2:0] spd, input string nm);
    fast = f; speed = spd;
    btn_play = 1'b1; step(); btn_play = 1'b0;
    nvec++;
    if (state !== 2'b10) begin
      nerr++;
      $display("FAIL %s_start state got %b exp 10", nm, state);
    end
    step(); step();
    foreach (exp_q[i]) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      nvec++;
      if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) begin
        nerr++;
        $display("FAIL %s_oe%0d oe %b we %b exp 0 1", nm, i, sram_oe_n, sram_we_n);
      end
      step();
      nvec++;
      if (dac_data !== exp_q[i] || state !== 2'b10 || sram_oe_n !== 1'b1) begin
        nerr++;
        $display("FAIL %s_dac%0d dac %h state %b oe %b exp %h 10 1",
                 nm, i, dac_data, state, sram_oe_n, exp_q[i]);
      end
      step();
      if (i == exp_q.size() - 1) begin
        nvec++;
        if (state !== 2'b00 || dac_data !== 16'h0) begin
          nerr++;
          $display("FAIL %s_end state %b dac %h exp 00 0", nm, state, dac_data);
        end
      end else begin
        step();
      end
    end
    step();
  endtask

  task automatic test_play_normal();
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    run_play(1'b1, 3'd0, "norm");
  endtask

  task automatic test_play_slow();
    exp_q = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3,
              16'd3, 16'd4, 16'd4, 16'd4, 16'd5, 16'd5, 16'd5};
    run_play(1'b0, 3'd2, "slow3");
  endtask

  task automatic test_play_fast();
    exp_q = '{16'd1, 16'd3, 16'd5};
    run_play(1'b1, 3'd1, "fast2");
  endtask

  task automatic test_pause();
    fast = 1'b1; speed = 3'd0;
    btn_play = 1'b1; step(); btn_play = 1'b0; step(); step();
    for (int i = 1; i <= 3; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      nvec++;
      if (dac_data !== 16'(i)) begin
        nerr++;
        $display("FAIL pause_pre%0d dac got %h exp %h", i, dac_data, i);
      end
      step(); step();
    end
    frame_tick = 1'b1; btn_pause = 1'b1; step();
    frame_tick = 1'b0; btn_pause = 1'b0;
    nvec++;
    if (state !== 2'b11 || sram_oe_n !== 1'b1 || dac_data !== 16'h0) begin
      nerr++;
      $display("FAIL pause_enter state %b oe %b dac %h exp 11 1 0", state, sram_oe_n, dac_data);
    end
    step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      nvec++;
      if (sram_oe_n !== 1'b1 || dac_data !== 16'h0 || state !== 2'b11) begin
        nerr++;
        $display("FAIL pause_hold%0d oe %b dac %h state %b exp 1 0 11",
                 i, sram_oe_n, dac_data, state);
      end
      step(); step(); step();
    end
    btn_play = 1'b1; step(); btn_play = 1'b0; step(); step();
    for (int i = 4; i <= 5; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      nvec++;
      if (dac_data !== 16'(i)) begin
        nerr++;
        $display("FAIL pause_resume%0d dac got %h exp %h", i, dac_data, i);
      end
      step(); step();
    end
    nvec++;
    if (state !== 2'b00 || dac_data !== 16'h0) begin
      nerr++;
      $display("FAIL pause_end state %b dac %h exp 00 0", state, dac_data);
    end
  endtask

  task automatic test_full_depth();
    btn_rec = 1'b1; step(); btn_rec = 1'b0;
    force dut.u_addr.wptr_q = 19'h3FFFE;
    #1;
    release dut.u_addr.wptr_q;
    step();
    nvec++;
    if (rec_len !== 19'h3FFFE || state !== 2'b01) begin
      nerr++;
      $display("FAIL full_preload len %h state %b exp 3fffe 01", rec_len, state);
    end
    for (int i = 0; i < 2; i++) begin
      adc_data = 16'hA5A0 + 16'(i); frame_tick = 1'b1; step(); frame_tick = 1'b0;
      nvec++;
      if (sram_we_n !== 1'b0 || sram_addr !== 18'h3FFFE + 18'(i) ||
          sram_wdata !== 16'hA5A0 + 16'(i)) begin
        nerr++;
        $display("FAIL full_wr%0d we %b addr %h wd %h exp 0 %h %h",
                 i, sram_we_n, sram_addr, sram_wdata, 18'h3FFFE + 18'(i), 16'hA5A0 + 16'(i));
      end
      step();
      if (i == 0) begin
        step(); step();
      end
    end
    nvec++;
    if (state !== 2'b00 || rec_len !== 19'h40000 || sram_we_n !== 1'b1 ||
        sram_addr !== 18'h3FFFF) begin
      nerr++;
      $display("FAIL full_end state %b len %h we %b addr %h exp 00 40000 1 3ffff",
               state, rec_len, sram_we_n, sram_addr);
    end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    nvec++;
    if (sram_we_n !== 1'b1 || rec_len !== 19'h40000) begin
      nerr++;
      $display("FAIL full_nowrap we %b len %h exp 1 40000", sram_we_n, rec_len);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    fast = 1'b1; speed = 3'd0;
    btn_play = 1'b1; step(); btn_play = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    nvec++;
    if (sram_oe_n !== 1'b0) begin
      nerr++;
      $display("FAIL arst_pre oe got %b exp 0", sram_oe_n);
    end
    #1 rst_n = 1'b0;
    #1;
    nvec++;
    if (sram_oe_n !== 1'b1 || sram_we_n !== 1'b1 || state !== 2'b00 || rec_len !== 19'd0) begin
      nerr++;
      $display("FAIL arst_strobe oe %b we %b state %b len %0d exp 1 1 00 0",
               sram_oe_n, sram_we_n, state, rec_len);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_record();
    test_play_normal();
    test_play_slow();
    test_play_fast();
    test_pause();
    test_full_depth();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d vectors", nvec);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/audio_seq_ctrl.md
# audio_seq_ctrl

Record/playback sequencer for the audio path. Owns the single 256K×16 SRAM, sharing it between the ADC record stream and the DAC playback stream. It runs the transport state machine (idle/record/play/pause), generates all SRAM addresses and strobes, and applies fast/slow playback speed. It feeds one 16-bit sample per frame to the DAC serializer and takes one sample per frame from the ADC deserializer.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, sample width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_play  in  1  single-cycle pulse: start/resume playback
- btn_rec  in  1  single-cycle pulse: start recording at address 0
- btn_pause  in  1  single-cycle pulse: pause playback
- btn_stop  in  1  single-cycle pulse: return to idle
- speed  in  3  speed factor minus one; factor k = speed+1 (1..8)
- fast  in  1  1 = fast (skip samples), 0 = slow (repeat samples)
- frame_tick  in  1  one-cycle pulse per audio frame (LRCK edge, pre-synchronised)
- adc_data  in  16  recorded sample, valid on frame_tick
- sram_rdata  in  16  SRAM read data
- sram_addr  out  18  SRAM address
- sram_wdata  out  16  SRAM write data
- sram_we_n  out  1  write strobe, active low
- sram_oe_n  out  1  output enable, active low
- dac_data  out  16  sample to DAC serializer
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY, 11 PAUSE
- rec_len  out  19  samples recorded (0..262144)

## Operation
- Reset values: state IDLE, sram_addr 0, sram_wdata 0, sram_we_n 1, sram_oe_n 1, dac_data 0, rec_len 0, play pointer 0, repeat counter 0.
- Button priority per cycle: stop > rec > pause > play. Buttons illegal in the current state are ignored.
- IDLE: btn_rec → RECORD with write pointer 0 and rec_len 0. btn_play with rec_len ≠ 0 → PLAY with play pointer 0. btn_play with rec_len = 0 is ignored.
- RECORD, on each frame_tick:
  - write adc_data at the write pointer.
  - increment the write pointer and rec_len.
  - When rec_len reaches 262144 (address 0x3FFFF written), go to IDLE.
  - btn_stop → IDLE. rec_len keeps the count written so far.
- PLAY, on each frame_tick: read the sample at the play pointer and present it on dac_data, then advance the pointer.
  - fast=1: pointer += k.
  - fast=0: the same address is read on k consecutive frames (repeat counter 0..k−1), then pointer += 1.
  - When the next pointer is ≥ rec_len (19-bit compare, no wrap), go to IDLE after the current read completes.
- btn_pause in PLAY → PAUSE. The pointer and repeat counter are held and dac_data is forced to 0.
- btn_play in PAUSE → PLAY, resuming at the held pointer.
- btn_stop in PLAY/PAUSE → IDLE with dac_data 0.
- A speed or fast change mid-play takes effect at the next pointer advance. The repeat counter clears when fast=1.
- Entering IDLE from any state: dac_data 0, strobes deasserted.
- rec_len is never cleared except by reset or a new record.

## Timing
- frame_tick at cycle T:
  - RECORD: at T+1 sram_addr = write pointer, sram_wdata = adc_data captured at T, sram_we_n = 0 for exactly one cycle.
  - PLAY: at T+1 sram_addr = play pointer, sram_oe_n = 0 for one cycle. sram_rdata is registered into dac_data at the end of T+1, so it is visible at T+2.
- Latency from frame_tick to dac_data update: 2 cycles.
- we_n and oe_n are never low in the same cycle.
- A frame_tick during an access cycle is invalid; frames are ≥ 4 clk apart.
- A button arriving on the same cycle as frame_tick takes priority. The state changes at T+1 and no access is issued for that frame.
- Async reset mid-access deasserts both strobes immediately.

## Structure
- Shared package audio_pkg: state encoding constants (ST_IDLE, ST_REC, ST_PLAY, ST_PAUSE), SRAM_DEPTH = 262144, ADDR_W, DATA_W.
- One sub-module, audio_addr_gen: it owns the play/write pointers, repeat counter, speed step and end-of-data compare. The top module keeps the FSM and SRAM strobe timing.

## Test plan
- Reset then idle: all outputs at reset values. btn_play with rec_len 0 → state stays 00.
- Record 5 frames with adc_data 1..5, then btn_stop → SRAM 0..4 hold 1..5, rec_len = 5, state 00, one we_n pulse per frame at T+1.
- Play after that record, fast=1, speed=0 → dac_data 1,2,3,4,5 at tick+2, then IDLE and dac_data 0.
- Slow k=3 (fast=0, speed=2) → dac_data 1,1,1,2,2,2,…,5,5,5, then IDLE. fast=1 k=2 → 1,3,5, then IDLE.
- Pause at sample 3 for 4 frames, then btn_play → dac_data 0 during pause, resumes with 4.
- Force rec_len to full depth (262144 ticks, or a preloaded pointer at 0x3FFFE) → last write at 0x3FFFF, auto-IDLE, rec_len = 262144, no address wrap.
